vga_timing_gen: RTL

//   Source end of the VGA sync interface. Generates HSync/VSync with porches and
//   the column/row counts that the game renderer uses to pick each pixel colour.

---
 rtl/vga_timing_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-clock timing source for a VGA output. Free-running column/row
//   counters feed the game renderer; the renderer's RGB comes back some
//   fixed number of clocks later, is blanked outside the visible area and
//   leaves together with HSync/VSync so all pins line up.
// Ports
//   i_Clk, i_Reset            pixel clock, synchronous active-high reset
//   i_{Red,Grn,Blu}_Video     renderer colour for pixel (count - c_RENDER_DELAY)
//   o_Col_Count, o_Row_Count  current counts
//   o_Frame_Start             1-clock pulse when the counts wrap to (0,0)
//   o_HSync, o_VSync          active-low syncs, aligned with o_*_Video
//   o_{Red,Grn,Blu}_Video     blanked colour
module vga_timing_gen #(
  parameter int c_TOTAL_COLS   = 800,
  parameter int c_TOTAL_ROWS   = 525,
  parameter int c_ACTIVE_COLS  = 640,
  parameter int c_ACTIVE_ROWS  = 480,
  parameter int c_H_FRONT      = 16,
  parameter int c_H_SYNC       = 96,
  parameter int c_V_FRONT      = 10,
  parameter int c_V_SYNC       = 2,
  parameter int c_RENDER_DELAY = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video
);

  localparam logic [9:0] LAST_COL = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(c_TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(c_ACTIVE_ROWS);
  // Sync windows as [beg, end) in count space.
  localparam logic [9:0] HS_BEG   = 10'(c_ACTIVE_COLS + c_H_FRONT);
  localparam logic [9:0] HS_END   = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(c_ACTIVE_ROWS + c_V_FRONT);
  localparam logic [9:0] VS_END   = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC);

  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
  } tim_t;

  localparam tim_t TIM_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [9:0]                  col, row;
  logic                        frame_start;
  logic                        col_wrap, row_wrap;
  tim_t                        tim_raw;
  tim_t [c_RENDER_DELAY:0]     tim_pipe;
  logic [11:0]                 rgb_q;

  assign col_wrap = (col == LAST_COL);
  assign row_wrap = (row == LAST_ROW);

  always_comb begin
    tim_raw      = TIM_IDLE;
    tim_raw.act  = (col < ACT_COLS) && (row < ACT_ROWS);
    tim_raw.hs_n = !((col >= HS_BEG) && (col < HS_END));
    tim_raw.vs_n = !((row >= VS_BEG) && (row < VS_END));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col         <= '0;
      row         <= '0;
      frame_start <= 1'b0;
      rgb_q       <= '0;
      tim_pipe    <= {(c_RENDER_DELAY + 1){TIM_IDLE}};
    end else begin
      col <= col_wrap ? '0 : col + 10'd1;
      if (col_wrap) row <= row_wrap ? '0 : row + 10'd1;
      // Registered alongside the counts so it is high exactly while they read
      // (0,0) after a real wrap; reset release never produces a pulse.
      frame_start <= col_wrap && row_wrap;
      rgb_q       <= {i_Red_Video, i_Grn_Video, i_Blu_Video};
      // Decode delayed by RENDER_DELAY+1 to meet the once-registered colour.
      tim_pipe[0] <= tim_raw;
      for (int i = 1; i <= c_RENDER_DELAY; i++) tim_pipe[i] <= tim_pipe[i-1];
    end
  end

  assign o_Col_Count   = col;
  assign o_Row_Count   = row;
  assign o_Frame_Start = frame_start;
  assign o_HSync       = tim_pipe[c_RENDER_DELAY].hs_n;
  assign o_VSync       = tim_pipe[c_RENDER_DELAY].vs_n;
  assign o_Red_Video   = tim_pipe[c_RENDER_DELAY].act ? rgb_q[11:8] : 4'h0;
  assign o_Grn_Video   = tim_pipe[c_RENDER_DELAY].act ? rgb_q[7:4]  : 4'h0;
  assign o_Blu_Video   = tim_pipe[c_RENDER_DELAY].act ? rgb_q[3:0]  : 4'h0;

endmodule
